mux8_scan_seq: RTL and testbench



---
 rtl/mux_seq_pkg.sv | 31 +++
 rtl/mux_seq_hold_cnt.sv | 31 +++
 rtl/mux8_scan_seq.sv | 106 ++++++++++
 tb/tb_mux8_scan_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_seq_pkg.sv
// Shared types, sizes and scan-order constants for the mux8 scan sequencer.
// MUX_SEQ_MSB_FIRST_EN selects scan order 7..0; undefined gives 0..7.
package mux_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam int SEL_W  = 3;
  localparam int NUM_IN = 8;
  // Wide enough for SEL_HOLD-1 over the legal range 1..16.
  localparam int HOLD_W = 4;

`ifdef MUX_SEQ_MSB_FIRST_EN
  localparam logic [SEL_W-1:0] FIRST_IDX = 3'd7;
  localparam logic [SEL_W-1:0] LAST_IDX  = 3'd0;
`else
  localparam logic [SEL_W-1:0] FIRST_IDX = 3'd0;
  localparam logic [SEL_W-1:0] LAST_IDX  = 3'd7;
`endif

  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
`ifdef MUX_SEQ_MSB_FIRST_EN
    return idx - 3'd1;
`else
    return idx + 3'd1;
`endif
  endfunction

endpackage

// File: rtl/mux_seq_hold_cnt.sv
// Select-hold down-counter: clear loads SEL_HOLD-1, last_o flags the final
// hold cycle of the current select value.
module mux_seq_hold_cnt
  import mux_seq_pkg::*;
#(
  parameter int SEL_HOLD = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic last_o
);

  localparam logic [HOLD_W-1:0] RELOAD = HOLD_W'(SEL_HOLD - 1);

  logic [HOLD_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= RELOAD;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/mux8_scan_seq.sv
// Parallel-to-serial sequencer wrapped around an external 8:1 mux.
// Scan order is 7..0 when MUX_SEQ_MSB_FIRST_EN is defined, else 0..7.
module mux8_scan_seq
  import mux_seq_pkg::*;
#(
  parameter int SEL_HOLD = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic [7:0]  mux_i,
  output logic        S2,
  output logic        S1,
  output logic        S0,
  input  logic        z,
  output logic        sout,
  output logic        sout_valid,
  output logic        sout_first,
  output logic        sout_last,
  output logic        busy
);

  state_e              state_q;
  logic [SEL_W-1:0]    idx_q;
  logic [NUM_IN-1:0]   word_q;
  logic                sout_q;
  logic                sout_valid_q;
  logic                sout_first_q;
  logic                sout_last_q;

  logic hold_last;
  logic scanning;
  logic frame_end;
  logic accept;

  assign scanning  = (state_q == SCAN);
  assign frame_end = scanning && hold_last && (idx_q == LAST_IDX);
  assign in_ready  = rst_n && ((state_q == IDLE) || frame_end);
  assign accept    = in_valid && in_ready;

  mux_seq_hold_cnt #(
    .SEL_HOLD (SEL_HOLD)
  ) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (accept || (scanning && hold_last)),
    .en_i    (scanning),
    .last_o  (hold_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      word_q       <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      sout_first_q <= 1'b0;
      sout_last_q  <= 1'b0;
    end else begin
      sout_valid_q <= 1'b0;
      sout_first_q <= 1'b0;
      sout_last_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            word_q  <= in_data;
            idx_q   <= FIRST_IDX;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (hold_last) begin
            // z has had the full hold window to settle behind the select.
            sout_q       <= z;
            sout_valid_q <= 1'b1;
            sout_first_q <= (idx_q == FIRST_IDX);
            sout_last_q  <= (idx_q == LAST_IDX);
            if (idx_q == LAST_IDX) begin
              if (accept) begin
                word_q <= in_data;
                idx_q  <= FIRST_IDX;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              idx_q <= next_idx(idx_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mux_i        = word_q;
  assign {S2, S1, S0} = idx_q;
  assign sout         = sout_q;
  assign sout_valid   = sout_valid_q;
  assign sout_first   = sout_first_q;
  assign sout_last    = sout_last_q;
  assign busy         = scanning;

endmodule

// File: tb/tb_mux8_scan_seq.sv
// Bench for mux8_scan_seq: two instances (SEL_HOLD 1 and 3) with a behavioural
// 8:1 mux in the loop; honours MUX_SEQ_MSB_FIRST_EN for expected scan order.
module tb_mux8_scan_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic b;
    logic f;
    logic l;
    int   c;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic [7:0] seq;   // k-th serial bit in LSB-first order
  } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a;
  exp_t e_b;
  vec_t vecs[8];

  // instance A: SEL_HOLD = 1
  logic       rst_n_a, in_valid_a, in_ready_a, z_a;
  logic [7:0] in_data_a, mux_i_a;
  logic       s2_a, s1_a, s0_a, sout_a, sv_a, sf_a, sl_a, busy_a;
  // instance B: SEL_HOLD = 3
  logic       rst_n_b, in_valid_b, in_ready_b, z_b;
  logic [7:0] in_data_b, mux_i_b;
  logic       s2_b, s1_b, s0_b, sout_b, sv_b, sf_b, sl_b, busy_b;

  assign z_a = mux_i_a[{s2_a, s1_a, s0_a}];
  assign z_b = mux_i_b[{s2_b, s1_b, s0_b}];

  mux8_scan_seq #(.SEL_HOLD(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .mux_i(mux_i_a), .S2(s2_a), .S1(s1_a), .S0(s0_a),
    .z(z_a), .sout(sout_a), .sout_valid(sv_a), .sout_first(sf_a),
    .sout_last(sl_a), .busy(busy_a)
  );

  mux8_scan_seq #(.SEL_HOLD(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .mux_i(mux_i_b), .S2(s2_b), .S1(s1_b), .S0(s0_b),
    .z(z_b), .sout(sout_b), .sout_valid(sv_b), .sout_first(sf_b),
    .sout_last(sl_b), .busy(busy_b)
  );

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end else begin
      $display("ok   %s cycle=%0d value=%0h", name, cyc, act);
    end
  endtask

  // select value used at scan position k
  function automatic logic [2:0] ord(input int k);
`ifdef MUX_SEQ_MSB_FIRST_EN
    return 3'(7 - k);
`else
    return 3'(k);
`endif
  endfunction

  // convert an LSB-first serial sequence to the build's serial order
  function automatic logic [7:0] adj(input logic [7:0] seq);
`ifdef MUX_SEQ_MSB_FIRST_EN
    return {<<{seq}};
`else
    return seq;
`endif
  endfunction

  function automatic logic [16:0] pack_a();
    return {mux_i_a, s2_a, s1_a, s0_a, sout_a, sv_a, sf_a, sl_a, busy_a, in_ready_a};
  endfunction

  function automatic logic [16:0] pack_b();
    return {mux_i_b, s2_b, s1_b, s0_b, sout_b, sv_b, sf_b, sl_b, busy_b, in_ready_b};
  endfunction

  task automatic push(input bit to_b, input logic [7:0] seq, input int c, input int h);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.b = seq[k];
      e.f = (k == 0);
      e.l = (k == 7);
      e.c = c + 1 + (k + 1) * h;
      if (to_b) q_b.push_back(e);
      else      q_a.push_back(e);
    end
  endtask

  // call at a negedge with instance A idle; returns just after the accept edge
  task automatic send_a(input logic [7:0] d, input logic [7:0] seq, output int c);
    in_valid_a = 1'b1;
    in_data_a  = d;
    c = cyc;
    chk("accept_ready_a", in_ready_a, 1);
    push(1'b0, adj(seq), c, 1);
    @(posedge clk);
    #1 in_valid_a = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sv_a) begin
      if (q_a.size() == 0) begin
        chk("unexpected_sout_valid_a", 1, 0);
      end else begin
        e_a = q_a.pop_front();
        chk("sout_bit_first_last_a", {sout_a, sf_a, sl_a}, {e_a.b, e_a.f, e_a.l});
        chk("sout_cycle_a", cyc, e_a.c);
      end
    end
    if (sv_b) begin
      if (q_b.size() == 0) begin
        chk("unexpected_sout_valid_b", 1, 0);
      end else begin
        e_b = q_b.pop_front();
        chk("sout_bit_first_last_b", {sout_b, sf_b, sl_b}, {e_b.b, e_b.f, e_b.l});
        chk("sout_cycle_b", cyc, e_b.c);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    vecs[0] = '{8'hA5, 8'hA5};
    vecs[1] = '{8'h00, 8'h00};
    vecs[2] = '{8'hFF, 8'hFF};
    vecs[3] = '{8'h3C, 8'h3C};
    vecs[4] = '{8'h80, 8'h80};
    vecs[5] = '{8'h01, 8'h01};
    vecs[6] = '{8'h5A, 8'h5A};
    vecs[7] = '{8'hC3, 8'hC3};

    rst_n_a = 1'b0; in_valid_a = 1'b0; in_data_a = 8'h00;
    rst_n_b = 1'b0; in_valid_b = 1'b0; in_data_b = 8'h00;
    // in_valid high during reset must not be accepted
    repeat (2) @(negedge clk);
    in_valid_a = 1'b1; in_data_a = 8'hEE;
    @(negedge clk);
    chk("reset_state_a", pack_a(), 0);
    chk("reset_state_b", pack_b(), 0);
    in_valid_a = 1'b0;
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    @(negedge clk);
    chk("idle_ready_a", {in_ready_a, busy_a}, 2'b10);

    // single word with per-cycle busy/select/ready profile
    send_a(8'hA5, 8'hA5, c);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      chk("a5_busy", busy_a, (i <= 8));
      chk("a5_ready", in_ready_a, (i >= 8));
      if (i <= 8) chk("a5_select", {s2_a, s1_a, s0_a}, ord(i - 1));
    end
    @(negedge clk);
    chk("a5_queue_drained", q_a.size(), 0);

    // table-driven single frames
    for (int v = 0; v < 8; v++) begin
      send_a(vecs[v].data, vecs[v].seq, c);
      repeat (3) @(negedge clk);
      chk("vec_mux_i_held", mux_i_a, vecs[v].data);
      repeat (7) @(negedge clk);
      chk("vec_queue_drained", q_a.size(), 0);
      chk("vec_idle", busy_a, 0);
    end

    // back-to-back frames with in_valid held
    in_valid_a = 1'b1; in_data_a = 8'hFF; c = cyc;
    chk("b2b_ready_start", in_ready_a, 1);
    push(1'b0, adj(8'hFF), c, 1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) in_data_a = 8'h00;
      chk("b2b_ready", in_ready_a, (i == 8));
      if (i == 8) push(1'b0, adj(8'h00), c + 8, 1);
    end
    @(negedge clk);
    in_valid_a = 1'b0;
    chk("b2b_second_frame", {busy_a, mux_i_a}, {1'b1, 8'h00});
    repeat (9) @(negedge clk);
    chk("b2b_queue_drained", q_a.size(), 0);

    // in_valid during SCAN is ignored
    send_a(8'h81, 8'h81, c);
    repeat (3) @(negedge clk);
    in_valid_a = 1'b1; in_data_a = 8'h3C;
    chk("bp_ready_low", in_ready_a, 0);
    @(negedge clk);
    in_valid_a = 1'b0;
    @(negedge clk);
    chk("bp_word_kept", mux_i_a, 8'h81);
    repeat (6) @(negedge clk);
    chk("bp_queue_drained", q_a.size(), 0);
    chk("bp_idle", busy_a, 0);

    // reset mid-frame discards the partial frame
    send_a(8'h5A, 8'h5A, c);
    repeat (4) @(negedge clk);
    #1;
    q_a.delete();
    rst_n_a = 1'b0;
    @(negedge clk);
    chk("midreset_state", pack_a(), 0);
    rst_n_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("midreset_idle", {in_ready_a, busy_a}, 2'b10);
    send_a(8'hC3, 8'hC3, c);
    repeat (10) @(negedge clk);
    chk("midreset_refill_drained", q_a.size(), 0);

    // select hold of 3 on instance B
    @(negedge clk);
    in_valid_b = 1'b1; in_data_b = 8'h01; c = cyc;
    chk("hold3_ready_start", in_ready_b, 1);
    push(1'b1, adj(8'h01), c, 3);
    @(posedge clk);
    #1 in_valid_b = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      chk("hold3_busy", busy_b, (i <= 24));
      chk("hold3_ready", in_ready_b, (i >= 24));
      if (i <= 24) chk("hold3_select", {s2_b, s1_b, s0_b}, ord((i - 1) / 3));
    end
    @(negedge clk);
    chk("hold3_queue_drained", q_b.size(), 0);
    chk("final_queue_a_empty", q_a.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
